index_decoder: RTL and testbench

- Inverse of the codebase's priority encoder: converts a binary bit index into a WIDTH-bit one-hot vector.
- Used to turn a selected position back into a grant/clear vector for the request bitmap.
- Has a valid/ready handshake on both sides and a 2-entry elastic buffer (output register plus skid register), so it sustains full throughput under backpressure.
- Flags out-of-range indices and keeps a saturating count of decoded words.

---
 rtl/index_decoder.sv | 115 +++++++++++
 tb/tb_index_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/index_decoder.sv
// Binary index to one-hot decoder with a 2-entry elastic buffer and a saturating decode counter.
// Define THERMO_MASK_EN to add the out_mask thermometer output (bits at and above the index set).
module index_decoder #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned LOG_W = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOG_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_err,
`ifdef THERMO_MASK_EN
    output logic [WIDTH-1:0] out_mask,
`endif
    output logic [CNT_W-1:0] dec_cnt
);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] onehot;
`ifdef THERMO_MASK_EN
        logic [WIDTH-1:0] mask;
`endif
    } word_t;

    word_t            out_q, out_nxt;
    word_t            skid_q, skid_nxt;
    word_t            new_word;
    logic             out_valid_nxt;
    logic             skid_valid, skid_valid_nxt;
    logic             in_ready_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             fire;

    // Decode happens at acceptance; out-of-range indices yield an all-zero word.
    always_comb begin
        new_word     = '0;
        new_word.err = 32'(in_idx) >= WIDTH;
        if (!new_word.err) begin
            new_word.onehot = WIDTH'(1) << in_idx;
`ifdef THERMO_MASK_EN
            new_word.mask   = {WIDTH{1'b1}} << in_idx;
`endif
        end
    end

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    // Elastic buffer movement: skid always drains into the output register first.
    always_comb begin
        out_nxt        = out_q;
        skid_nxt       = skid_q;
        out_valid_nxt  = out_valid;
        skid_valid_nxt = skid_valid;
        cnt_nxt        = dec_cnt;

        if (!out_valid || fire) begin
            if (skid_valid) begin
                out_nxt       = skid_q;
                out_valid_nxt = 1'b1;
                if (accept) begin
                    skid_nxt = new_word;
                end else begin
                    skid_valid_nxt = 1'b0;
                end
            end else if (accept) begin
                out_nxt       = new_word;
                out_valid_nxt = 1'b1;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            skid_nxt       = new_word;
            skid_valid_nxt = 1'b1;
        end

        if (fire && (dec_cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = dec_cnt + CNT_W'(1);
        end

        in_ready_nxt = ~skid_valid_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            dec_cnt    <= '0;
        end else begin
            out_q      <= out_nxt;
            skid_q     <= skid_nxt;
            out_valid  <= out_valid_nxt;
            skid_valid <= skid_valid_nxt;
            in_ready   <= in_ready_nxt;
            dec_cnt    <= cnt_nxt;
        end
    end

    assign out_onehot = out_q.onehot;
    assign out_err    = out_q.err;
`ifdef THERMO_MASK_EN
    assign out_mask   = out_q.mask;
`endif

endmodule

// File: tb/tb_index_decoder.sv
// Directed bench for index_decoder: two instances (WIDTH=16 and WIDTH=12) share one stimulus,
// checked each cycle against a queue-based buffer model plus hand-computed literals.
module tb_index_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_idx;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [15:0] a_onehot;
    logic [2:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [11:0] b_onehot;
    logic [2:0]  b_cnt;
`ifdef THERMO_MASK_EN
    logic [15:0] a_mask;
    logic [11:0] b_mask;
`endif

    int checks = 0;
    int errors = 0;
    int q[$];
    int fires;

    index_decoder #(.WIDTH(16), .LOG_W(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_idx(in_idx),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_onehot(a_onehot), .out_err(a_out_err),
`ifdef THERMO_MASK_EN
        .out_mask(a_mask),
`endif
        .dec_cnt(a_cnt)
    );

    index_decoder #(.WIDTH(12), .LOG_W(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_idx(in_idx),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_onehot(b_onehot), .out_err(b_out_err),
`ifdef THERMO_MASK_EN
        .out_mask(b_mask),
`endif
        .dec_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_oh(input int idx, input int w);
        return (idx < w) ? (64'(1) << idx) : 64'(0);
    endfunction

    function automatic logic [63:0] exp_mask(input int idx, input int w);
        return (idx < w) ? (((64'(1) << w) - 64'(1)) & ~((64'(1) << idx) - 64'(1))) : 64'(0);
    endfunction

    function automatic logic [63:0] exp_cnt(input int n);
        return 64'((n > 7) ? 7 : n);
    endfunction

    // Model: a FIFO holding at most two decoded words; head is what the output shows.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fires <= 0;
        end else if (q.size() > 0 && out_ready) begin
            fires <= fires + 1;
            if (in_valid && q.size() < 2) q.push_back(int'(in_idx));
            void'(q.pop_front());
        end else if (in_valid && q.size() < 2) begin
            q.push_back(int'(in_idx));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
            chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
            chk("a_in_ready", 64'(a_in_ready), 64'(q.size() < 2));
            chk("b_in_ready", 64'(b_in_ready), 64'(q.size() < 2));
            chk("a_dec_cnt", 64'(a_cnt), exp_cnt(fires));
            chk("b_dec_cnt", 64'(b_cnt), exp_cnt(fires));
            if (q.size() > 0) begin
                chk("a_onehot", 64'(a_onehot), exp_oh(q[0], 16));
                chk("b_onehot", 64'(b_onehot), exp_oh(q[0], 12));
                chk("a_err", 64'(a_out_err), 64'(q[0] >= 16));
                chk("b_err", 64'(b_out_err), 64'(q[0] >= 12));
`ifdef THERMO_MASK_EN
                chk("a_mask", 64'(a_mask), exp_mask(q[0], 16));
                chk("b_mask", 64'(b_mask), exp_mask(q[0], 12));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_idx = 4'd0; out_ready = 1'b1;
        step(); step();
        chk("rst_valid", 64'(a_out_valid), 64'(0));
        chk("rst_in_ready", 64'(a_in_ready), 64'(1));
        chk("rst_cnt", 64'(a_cnt), 64'(0));
        chk("rst_onehot", 64'(a_onehot), 64'(0));
        rst = 1'b0;

        // single word
        in_valid = 1'b1; in_idx = 4'd5; step(); in_valid = 1'b0;
        chk("single_a_onehot", 64'(a_onehot), 64'h0020);
        chk("single_b_onehot", 64'(b_onehot), 64'h020);
        chk("single_a_err", 64'(a_out_err), 64'(0));
`ifdef THERMO_MASK_EN
        chk("single_a_mask", 64'(a_mask), 64'hFFE0);
        chk("single_b_mask", 64'(b_mask), 64'hFE0);
`endif
        step();
        chk("single_cnt", 64'(a_cnt), 64'(1));

        // out of range on the 12-wide instance
        in_valid = 1'b1; in_idx = 4'd13; step(); in_valid = 1'b0;
        chk("oor_b_err", 64'(b_out_err), 64'(1));
        chk("oor_b_onehot", 64'(b_onehot), 64'h000);
        chk("oor_a_onehot", 64'(a_onehot), 64'h2000);
        chk("oor_a_err", 64'(a_out_err), 64'(0));
`ifdef THERMO_MASK_EN
        chk("oor_b_mask", 64'(b_mask), 64'h000);
`endif
        step();
        chk("oor_cnt", 64'(b_cnt), 64'(2));

        // streaming
        in_valid = 1'b1; in_idx = 4'd0; step();
        in_idx = 4'd1;
        chk("stream0", 64'(a_onehot), 64'h0001);
        step();
        in_idx = 4'd15;
        chk("stream1", 64'(a_onehot), 64'h0002);
        step();
        in_valid = 1'b0;
        chk("stream15", 64'(a_onehot), 64'h8000);
        chk("stream_in_ready", 64'(a_in_ready), 64'(1));
        step();

        // backpressure: third word stalls until the skid drains
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 4'd3; step();
        in_idx = 4'd7; step();
        in_idx = 4'd9;
        chk("bp_in_ready", 64'(a_in_ready), 64'(0));
        step(); step();
        chk("bp_hold", 64'(a_onehot), 64'h0008);
        chk("bp_still_full", 64'(a_in_ready), 64'(0));
        out_ready = 1'b1; step();
        chk("bp_second", 64'(a_onehot), 64'h0080);
        chk("bp_in_ready_back", 64'(a_in_ready), 64'(1));
        step(); in_valid = 1'b0;
        chk("bp_third", 64'(a_onehot), 64'h0200);
        step();

        // async reset with skid full
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 4'd2; step();
        in_idx = 4'd4; step(); in_valid = 1'b0;
        chk("ar_full", 64'(a_in_ready), 64'(0));
        rst = 1'b1; #1;
        chk("ar_a_valid", 64'(a_out_valid), 64'(0));
        chk("ar_b_valid", 64'(b_out_valid), 64'(0));
        chk("ar_in_ready", 64'(a_in_ready), 64'(1));
        chk("ar_cnt", 64'(a_cnt), 64'(0));
        #1 rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_idx = 4'd6; step();
        chk("ar_first", 64'(a_onehot), 64'h0040);

        // saturation: ten transfers on a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            in_idx = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("sat_a_cnt", 64'(a_cnt), 64'(7));
        chk("sat_b_cnt", 64'(b_cnt), 64'(7));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
